// File: rtl/reg_write_queue.sv
// Register-bank write queue: circular FIFO draining one write per cycle onto
// a one-hot bank enable, with read-port forwarding of pending write data.
module reg_write_queue #(
  parameter int unsigned DATA_LENGTH = 32,
  parameter int unsigned ADDR_LENGTH = 5,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_LENGTH-1:0]        wr_addr,
  input  logic [DATA_LENGTH-1:0]        wr_data,
  output logic [DATA_LENGTH-1:0]        d,
  output logic [(2**ADDR_LENGTH)-1:0]   en,
  input  logic [ADDR_LENGTH-1:0]        rd_addr1,
  input  logic [ADDR_LENGTH-1:0]        rd_addr2,
  output logic                          fwd_hit1,
  output logic                          fwd_hit2,
  output logic [DATA_LENGTH-1:0]        fwd_data1,
  output logic [DATA_LENGTH-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          idle
);

  localparam int unsigned NREG = 2 ** ADDR_LENGTH;
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;

  logic [ADDR_LENGTH-1:0] addr_mem [DEPTH];
  logic [DATA_LENGTH-1:0] data_mem [DEPTH];

  logic [PW-1:0]          head_q, head_d;
  logic [PW-1:0]          tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  logic [NREG-1:0]        en_q, en_d;
  logic [DATA_LENGTH-1:0] d_q, d_d;

  logic push, pop;

  // Push/pop decisions and next-state; address 0 completes the handshake but is dropped.
  always_comb begin
    push    = wr_valid && wr_ready && (wr_addr != '0);
    pop     = (count_q != '0);
    head_d  = head_q;
    tail_d  = tail_q;
    en_d    = '0;
    d_d     = d_q;
    if (pop) begin
      head_d            = PW'(head_q + PW'(1));
      en_d[addr_mem[head_q]] = 1'b1;
      d_d               = data_mem[head_q];
    end
    if (push) begin
      tail_d = PW'(tail_q + PW'(1));
    end
    count_d = CW'(count_q + CW'(push) - CW'(pop));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      en_q    <= '0;
      d_q     <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      en_q    <= en_d;
      d_q     <= d_d;
    end
  end

  // Entry storage; validity is implied by head/count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_q] <= wr_addr;
      data_mem[tail_q] <= wr_data;
    end
  end

  // Forwarding: scan oldest (bank-side entry) to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    idx       = '0;
    if (rd_addr1 != '0 && en_q[rd_addr1]) begin
      fwd_hit1  = 1'b1;
      fwd_data1 = d_q;
    end
    if (rd_addr2 != '0 && en_q[rd_addr2]) begin
      fwd_hit2  = 1'b1;
      fwd_data2 = d_q;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = PW'(head_q + PW'(i));
      if (CW'(i) < count_q) begin
        if (rd_addr1 != '0 && addr_mem[idx] == rd_addr1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_mem[idx];
        end
        if (rd_addr2 != '0 && addr_mem[idx] == rd_addr2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_mem[idx];
        end
      end
    end
  end

  assign wr_ready = (count_q < CW'(DEPTH));
  assign count    = count_q;
  assign idle     = (count_q == '0) && (en_q == '0);
  assign en       = en_q;
  assign d        = d_q;

endmodule

// File: tb/tb_reg_write_queue.sv
// Randomized bench for reg_write_queue against a queue-based reference model,
// plus hand-computed literal expectations for the key scenarios.
module tb_reg_write_queue;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NREG  = 32;
  localparam int unsigned CW    = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_valid;
  logic            wr_ready;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [DW-1:0]   d;
  logic [NREG-1:0] en;
  logic [AW-1:0]   rd_addr1, rd_addr2;
  logic            fwd_hit1, fwd_hit2;
  logic [DW-1:0]   fwd_data1, fwd_data2;
  logic [CW-1:0]   count;
  logic            idle;

  always #5 clk = ~clk;

  reg_write_queue #(.DATA_LENGTH(DW), .ADDR_LENGTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .d(d), .en(en),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count), .idle(idle)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] v;
  } ent_t;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  ent_t          q[$];
  bit            m_en_v;
  logic [AW-1:0] m_en_a;
  logic [DW-1:0] m_d;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  function automatic void model_reset();
    q.delete();
    m_en_v = 1'b0;
    m_en_a = '0;
    m_d    = '0;
  endfunction

  function automatic void fwd_model(input logic [AW-1:0] rd, output bit hit, output logic [DW-1:0] dat);
    hit = 1'b0;
    dat = '0;
    if (rd != '0) begin
      if (m_en_v && m_en_a == rd) begin
        hit = 1'b1;
        dat = m_d;
      end
      foreach (q[i]) begin
        if (q[i].a == rd) begin
          hit = 1'b1;
          dat = q[i].v;
        end
      end
    end
  endfunction

  task automatic model_check();
    bit            h1, h2;
    logic [DW-1:0] f1, f2;
    logic [NREG-1:0] exp_en;
    exp_en = '0;
    if (m_en_v) exp_en[m_en_a] = 1'b1;
    fwd_model(rd_addr1, h1, f1);
    fwd_model(rd_addr2, h2, f2);
    chk("wr_ready",  64'(wr_ready),  64'(q.size() < DEPTH));
    chk("count",     64'(count),     64'(q.size()));
    chk("idle",      64'(idle),      64'(q.size() == 0 && !m_en_v));
    chk("en",        64'(en),        64'(exp_en));
    chk("d",         64'(d),         64'(m_d));
    chk("fwd_hit1",  64'(fwd_hit1),  64'(h1));
    chk("fwd_data1", 64'(fwd_data1), 64'(f1));
    chk("fwd_hit2",  64'(fwd_hit2),  64'(h2));
    chk("fwd_data2", 64'(fwd_data2), 64'(f2));
  endtask

  // One clock cycle: drive inputs, check outputs, then advance the model at the edge.
  task automatic cycle(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] dat,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    bit   push, pop;
    ent_t e;
    @(negedge clk);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = dat;
    rd_addr1 = r1;
    rd_addr2 = r2;
    #1;
    model_check();
    push = v && (q.size() < DEPTH) && (a != '0);
    pop  = (q.size() > 0);
    @(posedge clk);
    if (pop) begin
      e      = q.pop_front();
      m_en_v = 1'b1;
      m_en_a = e.a;
      m_d    = e.v;
    end else begin
      m_en_v = 1'b0;
    end
    if (push) begin
      e.a = a;
      e.v = dat;
      q.push_back(e);
    end
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(($urandom_range(0, 9) < 7), AW'($urandom_range(0, 7)), $urandom,
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    rst      = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr1 = 5'd5;
    rd_addr2 = 5'd7;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset wr_ready", 64'(wr_ready), 64'd1);
    chk("reset idle",     64'(idle),     64'd1);
    chk("reset count",    64'(count),    64'd0);
    chk("reset en",       64'(en),       64'd0);
    chk("reset fwd_hit1", 64'(fwd_hit1), 64'd0);
    chk("reset fwd_data2", 64'(fwd_data2), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single write to register 5
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    #2;
    chk("single count", 64'(count), 64'd1);
    chk("single en0",   64'(en),    64'd0);
    cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #2;
    chk("single en",    64'(en),    64'h20);
    chk("single d",     64'(d),     64'hDEADBEEF);
    cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #2;
    chk("single en off", 64'(en),   64'd0);
    chk("single idle",   64'(idle), 64'd1);
    chk("single d hold", 64'(d),    64'hDEADBEEF);

    // Address-0 request is consumed but never queued
    cycle(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    #2;
    chk("x0 count",    64'(count),    64'd0);
    chk("x0 en",       64'(en),       64'd0);
    chk("x0 fwd_hit1", 64'(fwd_hit1), 64'd0);
    cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #2;
    chk("x0 en later", 64'(en), 64'd0);

    // Forward priority: youngest write to register 7 wins
    cycle(1'b1, 5'd7, 32'h11, 5'd7, 5'd0);
    #2;
    chk("fwd first hit",  64'(fwd_hit1),  64'd1);
    chk("fwd first data", 64'(fwd_data1), 64'h11);
    cycle(1'b1, 5'd7, 32'h22, 5'd7, 5'd0);
    #2;
    chk("fwd young hit",  64'(fwd_hit1),  64'd1);
    chk("fwd young data", 64'(fwd_data1), 64'h22);
    cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
    #2;
    chk("fwd bank en",    64'(en),        64'h80);
    chk("fwd bank data",  64'(fwd_data1), 64'h22);
    cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
    #2;
    chk("fwd drained hit",  64'(fwd_hit1),  64'd0);
    chk("fwd drained data", 64'(fwd_data1), 64'd0);

    // Back-to-back writes to registers 1..6, then drain
    for (int a = 1; a <= 6; a++) cycle(1'b1, AW'(a), DW'(a * 16), 5'd3, 5'd6);
    for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, 32'h0, 5'd3, 5'd6);

    rand_cycles(1500);

    // Asynchronous reset with writes in flight
    cycle(1'b1, 5'd9, 32'hA1, 5'd9, 5'd10);
    cycle(1'b1, 5'd10, 32'hA2, 5'd9, 5'd10);
    cycle(1'b1, 5'd11, 32'hA3, 5'd9, 5'd10);
    #2;
    rst = 1'b0;
    #1;
    chk("mid-rst en",       64'(en),       64'd0);
    chk("mid-rst count",    64'(count),    64'd0);
    chk("mid-rst wr_ready", 64'(wr_ready), 64'd1);
    chk("mid-rst idle",     64'(idle),     64'd1);
    chk("mid-rst fwd_hit1", 64'(fwd_hit1), 64'd0);
    model_reset();
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0, 5'd0, 32'h0, 5'd9, 5'd11);

    rand_cycles(1500);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_write_queue.md
REG_WRITE_QUEUE -- requirements
Module: reg_write_queue

Interface
REQ-001 Parameter DATA_LENGTH, default 32: data width of write data, bank data and forwarded data.
REQ-002 Parameter ADDR_LENGTH, default 5: register address width; bank has 2**ADDR_LENGTH registers.
REQ-003 Parameter DEPTH, default 4: write queue entries; power of two, 2..16.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 wr_valid  input  1  write request valid.
REQ-007 wr_ready  output  1  queue can accept a request.
REQ-008 wr_addr  input  ADDR_LENGTH  destination register.
REQ-009 wr_data  input  DATA_LENGTH  write data.
REQ-010 d  output  DATA_LENGTH  data to register bank d.
REQ-011 en  output  2**ADDR_LENGTH  one-hot write enable to register bank en.
REQ-012 rd_addr1, rd_addr2  input  ADDR_LENGTH  read-port addresses for forwarding lookup.
REQ-013 fwd_hit1, fwd_hit2  output  1  pending write exists for rd_addrN.
REQ-014 fwd_data1, fwd_data2  output  DATA_LENGTH  newest pending data for rd_addrN.
REQ-015 count  output  $clog2(DEPTH)+1  queued entries.
REQ-016 idle  output  1  no queued entries and en all zero.

Function
REQ-017 Queue SHALL be a circular FIFO (head/tail pointers wrapping at DEPTH, count register).
REQ-018 wr_ready SHALL equal (count < DEPTH), combinational from registered state only; no dependence on wr_valid.
REQ-019 A push SHALL occur at an edge where wr_valid && wr_ready && wr_addr != 0.
REQ-020 Requests with wr_addr == 0 and wr_valid && wr_ready SHALL be consumed (handshake completes) but never enqueued; en[0] SHALL never assert.
REQ-021 A pop SHALL occur at every edge where count > 0; popped head loads registered outputs: en <= one-hot(head addr), d <= head data.
REQ-022 At an edge with count == 0, en SHALL load all-zero; d SHALL hold its previous value.
REQ-023 Latency: request pushed at edge N into empty queue SHALL appear on en/d after edge N+1; bank captures at edge N+2.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; push at full is impossible (wr_ready = 0), including in a cycle where a pop frees a slot.
REQ-025 Drain order SHALL equal acceptance order; throughput one write per cycle.
REQ-026 Forwarding lookup is combinational over all valid queue entries plus the entry currently driven on en/d (when en != 0).
REQ-027 fwd_hitN = 1 iff rd_addrN != 0 and some searched entry matches; fwd_dataN = data of the youngest match (queue tail side youngest, en/d entry oldest).
REQ-028 fwd_hitN = 0 implies fwd_dataN = 0.
REQ-029 Same-cycle incoming wr_data SHALL NOT be forwarded.
REQ-030 count, idle SHALL reflect registered state only.

Reset
REQ-031 rst low SHALL asynchronously clear head, tail, count, en, d and all entry valid state to zero.
REQ-032 During/after reset: wr_ready = 1, idle = 1, fwd_hit1 = fwd_hit2 = 0, fwd_data1 = fwd_data2 = 0.
REQ-033 Reset mid-operation SHALL discard all queued and in-flight writes; no en bit asserts until a new push after release.
REQ-034 First edge after rst deassertion SHALL operate normally.

Verification
REQ-035 Single write: push addr 5, data 0xDEADBEEF into empty queue -> next cycle en = 0x00000020, d = 0xDEADBEEF; cycle after en = 0; idle returns 1.
REQ-036 Fill: hold wr_valid with addrs 1..6, no gaps -> count never exceeds DEPTH 4 while drained steadily at 1/cycle, en sequence 0x2,0x4,0x8,0x10,0x20,0x40 in order, no loss or duplication.
REQ-037 Full backpressure: DEPTH+1 pushes in consecutive cycles with drain in progress -> wr_ready low exactly when count = 4, held request accepted later, order preserved.
REQ-038 x0 drop: push addr 0 data 0x12345678 -> handshake completes, count unchanged, en stays 0; rd_addr1 = 0 -> fwd_hit1 = 0.
REQ-039 Forward priority: queue addr 7 = 0x11 then addr 7 = 0x22, rd_addr1 = 7 -> fwd_hit1 = 1, fwd_data1 = 0x22; after both drain fwd_hit1 = 0.
REQ-040 Reset mid-queue: 3 entries queued, pull rst low between edges -> en = 0, count = 0, wr_ready = 1 immediately; no bank write after release.
